// File: rtl/result_drain_if.sv
// Result-row drain port bundle: upstream result capture side and
// downstream word stream side of the systolic array boundary.
interface result_drain_if #(
  parameter int N = 4,
  parameter int W = 16
);
  localparam int IW = $clog2(N);

  logic [N*W-1:0] res_in;
  logic           res_valid;
  logic           res_rdy;
  logic           res_clr;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [IW-1:0]  out_idx;

  modport master (
    input  res_in,
    input  res_valid,
    input  out_ready,
    output res_rdy,
    output res_clr,
    output out_data,
    output out_valid,
    output out_last,
    output out_idx
  );

  modport slave (
    output res_in,
    output res_valid,
    output out_ready,
    input  res_rdy,
    input  res_clr,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_idx
  );
endinterface

// File: rtl/result_drain.sv
// Snapshots a row of N BFLOAT16 results and serializes it one lane
// per handshake, clearing the upstream registers after each capture.
module result_drain #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                clr,
  result_drain_if.master      io,
  output logic [7:0]          frame_cnt,
  output logic                overrun
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    frame_q, frame_d;
  logic          ovr_q, ovr_d;
  logic          rclr_q;
  logic [W-1:0]  buf_q [N];

  logic at_last;
  logic send;
  logic rdy;
  logic cap;

  assign at_last = (idx_q == LAST);
  assign send    = (state_q == SEND);

  // The final handshake of a frame doubles as a capture slot so rows
  // can stream with no idle cycle between them.
  assign rdy = !send || (io.out_ready && at_last);
  assign cap = io.res_valid && rdy;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    ovr_d   = ovr_q | (io.res_valid & ~rdy);
    unique case (state_q)
      IDLE: begin
        if (io.res_valid) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (io.out_ready) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            frame_d = frame_q + 8'd1;
            idx_d   = '0;
            state_d = io.res_valid ? SEND : IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      ovr_q   <= 1'b0;
      rclr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
      rclr_q  <= cap;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= '0;
      end
    end else if (cap) begin
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= io.res_in[k*W +: W];
      end
    end
  end

  assign io.res_rdy   = rdy;
  assign io.res_clr   = rclr_q;
  assign io.out_valid = send;
  assign io.out_data  = send ? buf_q[idx_q] : '0;
  assign io.out_idx   = send ? idx_q : '0;
  assign io.out_last  = send && at_last;
  assign frame_cnt    = frame_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: directed frame scenarios plus a randomized
// run scored against a queue-based model of the word stream.
module tb_result_drain;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;
  localparam int VW = W + IW + 3;

  localparam logic [N*W-1:0] ROWA =
    {16'h0000, 16'hC040, 16'h4000, 16'h3F80};
  localparam logic [N*W-1:0] ROWB =
    {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] frame_cnt;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;
  int exp_frames = 0;

  result_drain_if #(.N(N), .W(W)) bus ();

  result_drain #(.N(N), .W(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .io        (bus),
    .frame_cnt (frame_cnt),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] lane(
    input logic [N*W-1:0] r,
    input int k
  );
    return r[k*W +: W];
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.out_valid, bus.out_last, bus.res_clr,
            bus.out_idx, bus.out_data};
  endfunction

  function automatic logic [VW-1:0] word_vec(
    input logic [N*W-1:0] r,
    input int k,
    input logic rc
  );
    return {1'b1, (k == N - 1), rc, IW'(k), lane(r, k)};
  endfunction

  task automatic test_reset;
    logic [VW-1:0] o;
    bus.res_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.res_in    = '0;
    clr = 1'b1;
    repeat (2) tick();
    o = obs_vec();
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0", o);
    end
    n_cmp++;
    if ({frame_cnt, overrun} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_cnt_ovr got %h/%b want 0/0",
               frame_cnt, overrun);
    end
    clr = 1'b0;
    tick();
    n_cmp++;
    if ({bus.res_rdy, bus.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release rdy/valid got %b%b want 10",
               bus.res_rdy, bus.out_valid);
    end
  endtask

  task automatic test_single;
    bus.res_in    = ROWA;
    bus.out_ready = 1'b1;
    bus.res_valid = 1'b1;
    n_cmp++;
    if (bus.res_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL single_rdy got %b want 1", bus.res_rdy);
    end
    tick();
    bus.res_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (obs_vec() !== word_vec(ROWA, k, k == 0)) begin
        n_err++;
        $display("FAIL single_lane%0d got %h want %h",
                 k, obs_vec(), word_vec(ROWA, k, k == 0));
      end
      tick();
    end
    exp_frames++;
    n_cmp++;
    if ({bus.out_valid, bus.res_clr, frame_cnt} !==
        {2'b00, 8'(exp_frames)}) begin
      n_err++;
      $display("FAIL single_end valid/clr/cnt got %b%b/%0d want 00/%0d",
               bus.out_valid, bus.res_clr, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_backpressure;
    bus.res_in    = ROWA;
    bus.out_ready = 1'b1;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    n_cmp++;
    if (obs_vec() !== word_vec(ROWA, 0, 1'b1)) begin
      n_err++;
      $display("FAIL bp_lane0 got %h want %h",
               obs_vec(), word_vec(ROWA, 0, 1'b1));
    end
    tick();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (obs_vec() !== word_vec(ROWA, 1, 1'b0)) begin
        n_err++;
        $display("FAIL bp_hold%0d got %h want %h",
                 c, obs_vec(), word_vec(ROWA, 1, 1'b0));
      end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k < N; k++) begin
      n_cmp++;
      if (obs_vec() !== word_vec(ROWA, k, 1'b0)) begin
        n_err++;
        $display("FAIL bp_lane%0d got %h want %h",
                 k, obs_vec(), word_vec(ROWA, k, 1'b0));
      end
      tick();
    end
    exp_frames++;
    n_cmp++;
    if ({bus.out_valid, frame_cnt} !== {1'b0, 8'(exp_frames)}) begin
      n_err++;
      $display("FAIL bp_end valid/cnt got %b/%0d want 0/%0d",
               bus.out_valid, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_back_to_back;
    logic [N*W-1:0] r;
    bus.res_in    = ROWA;
    bus.out_ready = 1'b1;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      r = (k < N) ? ROWA : ROWB;
      n_cmp++;
      if (obs_vec() !== word_vec(r, k % N, (k % N) == 0)) begin
        n_err++;
        $display("FAIL b2b_word%0d got %h want %h",
                 k, obs_vec(), word_vec(r, k % N, (k % N) == 0));
      end
      if (k == N - 1) begin
        bus.res_in    = ROWB;
        bus.res_valid = 1'b1;
        n_cmp++;
        if (bus.res_rdy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_rdy got %b want 1", bus.res_rdy);
        end
      end else begin
        bus.res_valid = 1'b0;
      end
      tick();
    end
    exp_frames += 2;
    n_cmp++;
    if ({bus.out_valid, overrun, frame_cnt} !==
        {2'b00, 8'(exp_frames)}) begin
      n_err++;
      $display("FAIL b2b_end valid/ovr/cnt got %b%b/%0d want 00/%0d",
               bus.out_valid, overrun, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_overrun;
    bus.res_in    = ROWA;
    bus.out_ready = 1'b1;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    bus.res_in    = ROWB;
    bus.res_valid = 1'b1;
    n_cmp++;
    if (bus.res_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_rdy got %b want 0", bus.res_rdy);
    end
    tick();
    bus.res_valid = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_set got %b want 1", overrun);
    end
    repeat (2) tick();
    bus.out_ready = 1'b1;
    for (int k = 1; k < N; k++) begin
      n_cmp++;
      if (obs_vec() !== word_vec(ROWA, k, 1'b0)) begin
        n_err++;
        $display("FAIL ovr_lane%0d got %h want %h",
                 k, obs_vec(), word_vec(ROWA, k, 1'b0));
      end
      tick();
    end
    exp_frames++;
    n_cmp++;
    if ({bus.out_valid, overrun, frame_cnt} !==
        {2'b01, 8'(exp_frames)}) begin
      n_err++;
      $display("FAIL ovr_end valid/ovr/cnt got %b%b/%0d want 01/%0d",
               bus.out_valid, overrun, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_midframe_clr;
    bus.res_in    = ROWB;
    bus.out_ready = 1'b1;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (obs_vec() !== word_vec(ROWB, 2, 1'b0)) begin
      n_err++;
      $display("FAIL mclr_lane2 got %h want %h",
               obs_vec(), word_vec(ROWB, 2, 1'b0));
    end
    #3;
    clr = 1'b1;
    #1;
    exp_frames = 0;
    n_cmp++;
    if ({obs_vec(), frame_cnt, overrun, bus.res_rdy} !==
        {{VW{1'b0}}, 8'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL mclr_async out %h cnt %0d ovr %b rdy %b want 0/0/0/1",
               obs_vec(), frame_cnt, overrun, bus.res_rdy);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mclr_hold%0d valid got %b want 0",
                 c, bus.out_valid);
      end
    end
    clr = 1'b0;
    bus.res_in    = ROWA;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if ({obs_vec(), frame_cnt} !==
          {word_vec(ROWA, k, k == 0), 8'd0}) begin
        n_err++;
        $display("FAIL mclr_new%0d got %h/%0d want %h/0",
                 k, obs_vec(), frame_cnt, word_vec(ROWA, k, k == 0));
      end
      tick();
    end
    exp_frames = 1;
    n_cmp++;
    if (frame_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL mclr_cnt got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_wrap;
    bus.out_ready = 1'b1;
    bus.res_in    = ROWB;
    do begin
      bus.res_valid = 1'b1;
      tick();
      bus.res_valid = 1'b0;
      repeat (N) tick();
      exp_frames = (exp_frames + 1) % 256;
      if (exp_frames == 255 || exp_frames == 0) begin
        n_cmp++;
        if (frame_cnt !== 8'(exp_frames)) begin
          n_err++;
          $display("FAIL wrap_cnt got %0d want %0d",
                   frame_cnt, exp_frames);
        end
      end
    end while (exp_frames != 0);
  endtask

  task automatic test_random;
    logic [W-1:0]  m_q [$];
    int            m_frames;
    logic          m_ovr;
    logic          m_rclr;
    logic          m_valid;
    logic          m_rdy;
    logic [VW-1:0] e;
    m_frames = exp_frames;
    m_ovr    = overrun;
    m_rclr   = 1'b0;
    bus.res_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      m_valid = (m_q.size() != 0);
      e = m_valid ?
          {1'b1, m_q.size() == 1, m_rclr,
           IW'(N - m_q.size()), m_q[0]} :
          {2'b00, m_rclr, {(IW + W){1'b0}}};
      n_cmp++;
      if ({obs_vec(), frame_cnt, overrun} !==
          {e, 8'(m_frames), m_ovr}) begin
        n_err++;
        $display("FAIL rand_c%0d out %h cnt %0d ovr %b want %h %0d %b",
                 i, obs_vec(), frame_cnt, overrun, e, m_frames, m_ovr);
      end
      bus.res_valid = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.res_in    = {$urandom(), $urandom()};
      #1;
      m_rdy = !m_valid || (bus.out_ready && m_q.size() == 1);
      n_cmp++;
      if (bus.res_rdy !== m_rdy) begin
        n_err++;
        $display("FAIL rand_rdy%0d got %b want %b",
                 i, bus.res_rdy, m_rdy);
      end
      if (m_valid && bus.out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_frames = (m_frames + 1) % 256;
      end
      if (bus.res_valid && !m_rdy) m_ovr = 1'b1;
      m_rclr = bus.res_valid && m_rdy;
      if (m_rclr) begin
        for (int k = 0; k < N; k++) m_q.push_back(lane(bus.res_in, k));
      end
      tick();
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.res_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.res_in    = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_midframe_clr();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
